// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Two-digit BCD stopwatch sequencer with start, stop and clear control.
// Everything runs on Clock. A prescaler turns Clock into one count step
// every TICK_DIV cycles while running.
//
// Parameters:
//   TICK_DIV - Clock cycles per count step (>= 2)
//   MAX_SEC  - last displayed value before the count wraps to 00 (1..99)
//
// Ports:
//   Clock   - system clock
//   Reset   - asynchronous, active-high reset
//   Start   - level input, rising edge starts or resumes counting
//   Stop    - level input, rising edge pauses counting
//   Clear   - level input, rising edge returns to idle at 00
//   Ones    - BCD ones digit (drives HEX0 decoder)
//   Tens    - BCD tens digit (drives HEX1 decoder)
//   Running - high while counting
//   Tick    - one-cycle pulse on each count increment
//   Wrap    - one-cycle pulse on the increment that rolls MAX_SEC to 00
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_SEC  = 59
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  output logic [3:0] Ones,
  output logic [3:0] Tens,
  output logic       Running,
  output logic       Tick,
  output logic       Wrap
);

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  TERM     = PW'(TICK_DIV - 1);
  localparam logic [3:0]     MAX_TENS = 4'(MAX_SEC / 10);
  localparam logic [3:0]     MAX_ONES = 4'(MAX_SEC % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic            start_prev;
  logic            stop_prev;
  logic            clear_prev;

  logic            start_edge;
  logic            stop_edge;
  logic            clear_edge;

  // Rising-edge detection on the debounced button levels. The history
  // registers reset to 1 so a button held through reset release is not
  // mistaken for a fresh press.
  assign start_edge = Start & ~start_prev;
  assign stop_edge  = Stop  & ~stop_prev;
  assign clear_edge = Clear & ~clear_prev;

  // Single sequencer: state, prescaler, digits and all outputs update
  // together. Clear beats Stop beats Start. The prescaler only moves while
  // already in RUN with no Stop/Clear edge, so a pause keeps the partial
  // interval and a Stop on the terminal-count cycle defers that increment
  // to the first RUN cycle after resume.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      presc      <= '0;
      Ones       <= 4'd0;
      Tens       <= 4'd0;
      Running    <= 1'b0;
      Tick       <= 1'b0;
      Wrap       <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
    end else begin
      start_prev <= Start;
      stop_prev  <= Stop;
      clear_prev <= Clear;
      Tick       <= 1'b0;
      Wrap       <= 1'b0;

      if (clear_edge) begin
        state   <= IDLE;
        Running <= 1'b0;
        presc   <= '0;
        Ones    <= 4'd0;
        Tens    <= 4'd0;
      end else if (state == RUN && stop_edge) begin
        state   <= PAUSE;
        Running <= 1'b0;
      end else if (state != RUN && start_edge) begin
        state   <= RUN;
        Running <= 1'b1;
      end else if (state == RUN) begin
        if (presc == TERM) begin
          presc <= '0;
          Tick  <= 1'b1;
          if (Tens == MAX_TENS && Ones == MAX_ONES) begin
            Ones <= 4'd0;
            Tens <= 4'd0;
            Wrap <= 1'b1;
          end else if (Ones == 4'd9) begin
            Ones <= 4'd0;
            Tens <= Tens + 4'd1;
          end else begin
            Ones <= Ones + 4'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4, MAX_SEC=59).
// A reference model tracks the stopwatch as an integer seconds value, an
// integer count of cycles into the current interval and a running flag;
// the displayed digits are derived from the value with / and %.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MAX_SEC  = 59;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic [3:0] Ones;
  logic [3:0] Tens;
  logic       Running;
  logic       Tick;
  logic       Wrap;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit m_run;
  int m_val;
  int m_cnt;
  bit m_tick;
  bit m_wrap;
  bit m_ps, m_pp, m_pc;

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .MAX_SEC (MAX_SEC)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Stop   (Stop),
    .Clear  (Clear),
    .Ones   (Ones),
    .Tens   (Tens),
    .Running(Running),
    .Tick   (Tick),
    .Wrap   (Wrap)
  );

  // 10-unit clock period
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_run  = 1'b0;
    m_val  = 0;
    m_cnt  = 0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    m_ps   = 1'b1;
    m_pp   = 1'b1;
    m_pc   = 1'b1;
  endtask

  // One clock of the stopwatch rules, using the inputs present at the edge
  task automatic modelClock();
    bit se, pe, ce;
    se = Start & ~m_ps;
    pe = Stop  & ~m_pp;
    ce = Clear & ~m_pc;
    m_ps = Start;
    m_pp = Stop;
    m_pc = Clear;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (ce) begin
      m_run = 1'b0;
      m_val = 0;
      m_cnt = 0;
    end else if (m_run && pe) begin
      m_run = 1'b0;
    end else if (!m_run && se) begin
      m_run = 1'b1;
    end else if (m_run) begin
      m_cnt++;
      if (m_cnt == TICK_DIV) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        if (m_val == MAX_SEC) begin
          m_val  = 0;
          m_wrap = 1'b1;
        end else begin
          m_val++;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".Ones"},    {4'd0, Ones},    8'(m_val % 10));
    checkOutput({tag, ".Tens"},    {4'd0, Tens},    8'(m_val / 10));
    checkOutput({tag, ".Running"}, {7'd0, Running}, {7'd0, m_run});
    checkOutput({tag, ".Tick"},    {7'd0, Tick},    {7'd0, m_tick});
    checkOutput({tag, ".Wrap"},    {7'd0, Wrap},    {7'd0, m_wrap});
  endtask

  // Drive the buttons, advance one clock, update the model, check outputs
  task automatic applyStimulus(input bit s, input bit p, input bit c);
    Start = s;
    Stop  = p;
    Clear = c;
    @(posedge Clock);
    if (Reset) modelReset();
    else       modelClock();
    #1;
    checkAll("cycle");
  endtask

  // Idle the buttons until the DUT ticks; returns cycles taken, 0 on timeout
  task automatic waitTick(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (Tick === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) checkOutput("tick_timeout", 8'd0, 8'd1);
  endtask

  // Run until the model value reaches target
  task automatic waitValue(input int target);
    int n;
    for (int i = 0; i < 200 && m_val != target; i++) waitTick(3 * TICK_DIV, n);
    checkOutput("reach_value", 8'(m_val), 8'(target));
  endtask

  initial begin
    int n;
    logic [3:0] held_ones, held_tens;

    Reset = 1'b0;
    Start = 1'b1;
    Stop  = 1'b0;
    Clear = 1'b0;
    modelReset();
    #2 Reset = 1'b1;
    #1;
    checkAll("reset");

    // Release reset with Start held: must stay idle
    applyStimulus(1'b1, 1'b0, 1'b0);
    Reset = 1'b0;
    $display("[TB] reset released with Start held");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_start_idle", {7'd0, Running}, 8'd0);

    // Start pulse, first tick latency
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_running", {7'd0, Running}, 8'd1);
    waitTick(20, n);
    checkOutput("first_tick_latency", 8'(n), 8'(TICK_DIV));
    checkOutput("first_tick_ones", {4'd0, Ones}, 8'd1);

    // Ones to 9, then carry into tens
    for (int i = 0; i < 8; i++) waitTick(20, n);
    checkOutput("ones_nine", {4'd0, Ones}, 8'd9);
    waitTick(20, n);
    checkOutput("carry_tens", {4'd0, Tens}, 8'd1);
    checkOutput("carry_ones", {4'd0, Ones}, 8'd0);

    // Wrap at MAX_SEC
    waitValue(59);
    waitTick(20, n);
    checkOutput("wrap_pulse", {7'd0, Wrap}, 8'd1);
    checkOutput("wrap_tick",  {7'd0, Tick}, 8'd1);
    checkOutput("wrap_value", {Tens, Ones}, 8'h00);

    // Pause mid-interval and resume
    $display("[TB] pause/resume");
    waitTick(20, n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pause_running", {7'd0, Running}, 8'd0);
    held_ones = Ones;
    held_tens = Tens;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pause_frozen", {Tens, Ones}, {held_tens, held_ones});
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitTick(20, n);
    checkOutput("resume_latency", 8'(n), 8'd2);

    // Stop on the terminal-count cycle
    $display("[TB] stop on terminal count");
    for (int i = 0; i < TICK_DIV - 1; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    held_ones = Ones;
    held_tens = Tens;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("term_stop_no_tick", {7'd0, Tick}, 8'd0);
    checkOutput("term_stop_digits", {Tens, Ones}, {held_tens, held_ones});
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("term_resume_tick", {7'd0, Tick}, 8'd1);

    // Clear with Stop and Start in the same cycle at 37
    $display("[TB] clear priority");
    waitValue(37);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clear_value",   {Tens, Ones}, 8'h00);
    checkOutput("clear_running", {7'd0, Running}, 8'd0);
    checkOutput("clear_no_tick", {7'd0, Tick}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitTick(20, n);
    checkOutput("after_clear_latency", 8'(n), 8'(TICK_DIV));

    // Asynchronous reset between clock edges at 12
    $display("[TB] async reset mid-run");
    waitValue(12);
    #3 Reset = 1'b1;
    modelReset();
    #1;
    checkAll("async_reset");
    checkOutput("async_reset_digits", {Tens, Ones}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_idle", {7'd0, Running}, 8'd0);

    // Randomized button activity against the model
    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      bit s, p, c;
      s = Start;
      p = Stop;
      c = Clear;
      if ($urandom_range(15) == 0) s = ~s;
      if ($urandom_range(23) == 0) p = ~p;
      if ($urandom_range(99) == 0) c = ~c;
      applyStimulus(s, p, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequences the board's one-digit-per-second count display as a two-digit BCD stopwatch with start, stop and clear control.
- Replaces the divided-clock scheme with a single-clock design. A prescaler produces a one-cycle Tick enable, and all state runs on Clock.
- Sits between the debounced KEY inputs and the HEX decoders. Ones drives HEX0 and Tens drives HEX1 through the existing 7-segment decoder.

Parameters:
- TICK_DIV, 50000000: Clock cycles per count step. Minimum 2. Use 4 in simulation.
- MAX_SEC, 59: Last displayed value before wrap to 00. Range 1..99.

Ports:
- Clock  input  1  system clock (50 MHz on board)
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  level, active-high (top level drives ~KEY); rising edge starts or resumes
- Stop   input  1  level, active-high; rising edge pauses
- Clear  input  1  level, active-high; rising edge returns to idle at 00
- Ones   output 4  BCD ones digit, 0..9
- Tens   output 4  BCD tens digit, 0..9
- Running output 1  high while in RUN
- Tick   output 1  one-cycle pulse on each count increment
- Wrap   output 1  one-cycle pulse on the increment that rolls MAX_SEC to 00

Behaviour:
- Reset (async, any time, including mid-count):
  - State = IDLE; prescaler = 0; Ones = Tens = 0; Running = Tick = Wrap = 0.
  - Edge-detect history registers = 1, so a button held through reset release does not trigger.
- Edge detect:
  - Per input, edge = in & ~prev; prev <= in every cycle.
  - An edge seen at posedge k takes effect in the registers updated at posedge k. Outputs show the change after posedge k.
- FSM states: IDLE, RUN, PAUSE.
  - Priority per cycle: Clear > Stop > Start.
  - Clear edge (any state): go to IDLE; prescaler = 0; digits = 00; no Tick or Wrap that cycle, even if the prescaler was at terminal count.
  - Stop edge: RUN -> PAUSE. Ignored in IDLE and PAUSE.
  - Start edge: IDLE -> RUN, PAUSE -> RUN. Ignored in RUN.
- Prescaler:
  - Width is clog2(TICK_DIV).
  - Advances only while in RUN and no Stop/Clear edge is present that cycle.
  - When at TICK_DIV-1 and advancing: prescaler = 0, digits increment, Tick = 1 for the next cycle.
  - Holds its value in PAUSE, so resuming keeps the partial interval. Zeroed only by Reset or Clear.
- Timing:
  - First Tick after IDLE -> RUN occurs TICK_DIV cycles after the Start edge cycle.
  - A Stop edge in the terminal-count cycle suppresses that increment. The prescaler stays at TICK_DIV-1, and the increment fires on the first RUN cycle after resume.
- Digits:
  - BCD. Ones 9 -> 0 with Tens+1.
  - When the value equals MAX_SEC (Tens*10+Ones), the next increment gives 00 and Wrap = 1 alongside Tick.
  - Digits never hold a non-BCD value and never exceed MAX_SEC.
- Outputs:
  - All outputs are registered.
  - Running = (state == RUN).
  - Tick and Wrap are 0 on every non-increment cycle.

Test Plan:
- Reset, TICK_DIV=4, MAX_SEC=59:
  - Release Reset with Start held high -> stays IDLE, Ones = Tens = 0, Running = 0.
  - Drop Start, then pulse it -> Running = 1.
  - First Tick 4 cycles after the Start edge, Ones = 1.
  - Ones = 9 after 9 Ticks; next Tick gives Tens = 1, Ones = 0.
- Wrap (TICK_DIV=4):
  - Run 60 Ticks -> value 59 then 00.
  - Wrap = 1 only on the 00 transition, with Tick = 1 in the same cycle.
- Pause/resume (TICK_DIV=4):
  - Stop edge 2 cycles after a Tick -> Running = 0, digits frozen for 20 cycles.
  - Start edge -> next Tick exactly 2 RUN cycles later (partial interval preserved).
- Same-cycle Stop and terminal count (TICK_DIV=4):
  - Stop edge on the terminal-count cycle -> no Tick, digits unchanged.
  - Start edge -> Tick on the first RUN cycle.
- Clear and priority:
  - Clear, Stop and Start edges in the same cycle while at 37 -> IDLE, 00, no Tick.
  - Start edge later -> first Tick 4 cycles after it.
- Async reset mid-run:
  - Assert Reset between clock edges at value 12 -> outputs go to 0 immediately without waiting for a Clock edge.
  - State is IDLE after release.
